// File: rtl/debounce_edge_det_pkg.sv
// Shared definitions for the debounce/edge-detect input conditioner.
// The FSM state encoding is reused by downstream blocks that decode debouncer state.
package debounce_edge_det_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } deb_state_e;

  // The encoding puts the debounced level in bit 1 and "qualifying" in bit 0.
  function automatic logic state_level(input deb_state_e s);
    return s[1];
  endfunction

  function automatic logic state_busy(input deb_state_e s);
    return s[0];
  endfunction

endpackage

// File: rtl/debounce_edge_det_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/debounce_edge_det.sv
// Synchronise, debounce and edge-detect a raw asynchronous input.
// Outputs are a clean registered level plus one-cycle rise/fall pulses.
module debounce_edge_det
  import debounce_edge_det_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  generate
    if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES - 1) >= (64'd1 << CNT_W)) begin : g_bad_param
      $error("debounce_edge_det: DEBOUNCE_CYCLES out of range for CNT_W");
    end
  endgenerate

  logic       w_s2;
  deb_state_e r_state;
  deb_state_e w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic r_rise;
  logic r_fall;
  logic w_rise_nxt;
  logic w_fall_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (w_s2)
  );

  // NOTE: every flop here has an async reset so a mid-qualification reset
  // drops q and any pending pulse at once, without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // NOTE: all outputs of this block get a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;

    unique case (r_state)
      IDLE_LO: begin
        if (w_s2) begin
          w_state_nxt = CHK_HI;
          w_cnt_nxt   = ONE_CNT;
        end
      end

      // Rejection is tested first so a bounce on the terminal cycle wins.
      CHK_HI: begin
        if (!w_s2) begin
          w_state_nxt = IDLE_LO;
        end else if (r_cnt == TERM_CNT) begin
          w_state_nxt = IDLE_HI;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ONE_CNT;
        end
      end

      IDLE_HI: begin
        if (!w_s2) begin
          w_state_nxt = CHK_LO;
          w_cnt_nxt   = ONE_CNT;
        end
      end

      CHK_LO: begin
        if (w_s2) begin
          w_state_nxt = IDLE_HI;
        end else if (r_cnt == TERM_CNT) begin
          w_state_nxt = IDLE_LO;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ONE_CNT;
        end
      end

      default: w_state_nxt = IDLE_LO;
    endcase
  end

  assign q    = state_level(r_state);
  assign busy = state_busy(r_state);
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: doc/debounce_edge_det.md
Name: debounce_edge_det

Overview:
- Input-conditioning stage directly upstream of the async-reset D flip-flop.
- Takes a raw, asynchronous, possibly bouncing 1-bit input and synchronises it through two flops.
- Debounces it with a consecutive-cycle counter and FSM, then presents a clean level plus one-cycle rise/fall pulses.
- The debounced level is the clean d source for downstream flip-flops and counters.

Parameters:
- DEBOUNCE_CYCLES, default 1000: consecutive synchronised cycles the new value must hold before the output level changes. Legal range 2..2^CNT_W-1.
- CNT_W, default 16: width of the stability counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low. 0 clears all state immediately; normal operation while 1.
- din  input  1  raw asynchronous input (button/switch); no timing relation to clk.
- q  output  1  debounced level.
- rise  output  1  one-cycle pulse when q goes 0->1.
- fall  output  1  one-cycle pulse when q goes 1->0.
- busy  output  1  high while a candidate transition is being qualified (FSM in a CHK state).

Behaviour:
- Reset (rst=0, async): sync flops=0, cnt=0, FSM=IDLE_LO, q=0, rise=0, fall=0, busy=0. All outputs are registered.
- Synchroniser: s1<=din, s2<=s1; s2 is the only value the FSM sees.
- FSM states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO. q=1 in IDLE_HI and CHK_LO.
- IDLE_LO:
  - s2=1 -> CHK_HI, cnt<=1.
  - Otherwise hold, cnt<=0.
- CHK_HI:
  - s2=0 -> IDLE_LO, cnt<=0 (glitch rejected, no pulse).
  - Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE_HI, q<=1, rise<=1, cnt<=0.
  - Else cnt<=cnt+1.
- IDLE_HI and CHK_LO: mirror of IDLE_LO and CHK_HI with polarity inverted; the qualifying exit asserts fall.
- Latency: q changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the edge that first samples the new din value into s1 as edge 1. din must stay stable throughout.
- rise/fall:
  - Asserted in the same cycle q changes; deasserted on the next edge.
  - Never both high at once.
  - Never asserted while rst=0.
- busy=1 exactly in CHK_HI and CHK_LO.
- Boundary conditions:
  - Simultaneous abort and terminal count (s2 returns to q on the edge where cnt==DEBOUNCE_CYCLES-1): rejection wins, q unchanged.
  - Any bounce during CHK restarts qualification from scratch; partial counts are never retained.
  - Counter never wraps: it is bounded by the terminal compare, and CNT_W must satisfy DEBOUNCE_CYCLES-1 < 2^CNT_W.
  - Reset mid-qualification aborts immediately: q=0, no pulse.
  - din held high through reset release produces a normal qualified rise after DEBOUNCE_CYCLES+2 edges.
  - din toggling every cycle keeps q at its current value indefinitely; busy toggles.

Decomposition:
- Shared package/include holds the 2-bit FSM state encodings (IDLE_LO=0, CHK_HI=1, IDLE_HI=2, CHK_LO=3). Downstream blocks reuse it.
- One sub-module: sync_2ff (clk, rst async active-low, d, q), the 2-flop synchroniser.
- Counter, FSM and pulse registers live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, clk period 6):
- Reset hold: rst=0 with din toggling -> q=rise=fall=busy=0 throughout. Outputs clear immediately on rst falling, without waiting for a clock.
- Clean rise: din 0->1 and held -> busy=1 from edge 3. q=1 and rise=1 on edge 6 (sampling edge=1). rise=0 on edge 7, and only one pulse.
- Glitch rejection: din high for 2 cycles then low -> busy pulses, q stays 0, no rise.
- Abort at terminal count: din high for exactly 3 synchronised cycles, low on the 4th -> q stays 0, FSM back to IDLE_LO, cnt=0.
- Clean fall: from q=1, din 1->0 held -> q=0 and fall=1 on edge 6, rise never asserted.
- Reset mid-CHK: q=1, din low, rst pulled low during CHK_LO -> q=0 immediately and no fall pulse. After release with din=0, q stays 0 and no rise occurs.
